// File: rtl/otter_intr_ctrl.sv
// otter_intr_ctrl: synchronizes/edge-detects IRQs, latches pending, and takes traps or MRET redirects at instruction boundaries
module otter_intr_ctrl #(
  parameter int NUM_SRC     = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [NUM_SRC-1:0] IRQ,
  input  logic               CSR_ME,
  input  logic [31:0]        CSR_MTVEC,
  input  logic [31:0]        CSR_MEPC,
  input  logic               INSTR_DONE,
  input  logic               MRET,
  input  logic               MASK_WE,
  input  logic [NUM_SRC-1:0] MASK_WD,
  output logic               INT_TAKEN,
  output logic               PC_REDIRECT,
  output logic [31:0]        PC_TARGET,
  output logic               RESTORE_ME,
  output logic               MPIE,
  output logic [7:0]         CAUSE,
  output logic [NUM_SRC-1:0] PENDING,
  output logic [NUM_SRC-1:0] MASK
);
  typedef enum logic {RUN, HANDLER} state_t;
  state_t r_state;
  logic [SYNC_STAGES-1:0][NUM_SRC-1:0] r_sync;
  logic [NUM_SRC-1:0] r_prev, w_rise, w_elig, w_clr;
  logic [7:0] w_win;
  logic w_take, w_mret;
  assign w_rise = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign w_elig = PENDING & MASK;
  assign w_mret = INSTR_DONE && MRET;
  assign w_take = INSTR_DONE && !MRET && CSR_ME && (r_state == RUN) && (|w_elig);
  assign w_clr  = w_take ? (NUM_SRC'(1) << w_win) : '0;
  always_comb begin
    w_win = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) w_win = w_elig[i] ? 8'(i) : w_win;
  end
  // A fresh edge on the bit being serviced is kept: set is applied after clear.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_sync  <= '0;
      r_prev  <= '0;
      PENDING <= '0;
      MASK    <= '1;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], IRQ};
      r_prev  <= r_sync[SYNC_STAGES-1];
      PENDING <= (PENDING & ~w_clr) | w_rise;
      MASK    <= MASK_WE ? MASK_WD : MASK;
    end
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= RUN;
      INT_TAKEN   <= 1'b0;
      PC_REDIRECT <= 1'b0;
      RESTORE_ME  <= 1'b0;
      PC_TARGET   <= '0;
      MPIE        <= 1'b0;
      CAUSE       <= '0;
    end else begin
      INT_TAKEN   <= w_take;
      PC_REDIRECT <= w_take || w_mret;
      RESTORE_ME  <= w_mret;
      if (w_take) begin
        r_state   <= HANDLER;
        PC_TARGET <= CSR_MTVEC;
        MPIE      <= CSR_ME;
        CAUSE     <= w_win;
      end else if (w_mret) begin
        r_state   <= RUN;
        PC_TARGET <= CSR_MEPC;
      end
    end
  end
endmodule

// File: tb/tb_otter_intr_ctrl.sv
// tb_otter_intr_ctrl: directed stimulus with a redirect-event scoreboard for otter_intr_ctrl
module tb_otter_intr_ctrl;
  logic        CLK = 0, RESET = 1, CSR_ME = 0, INSTR_DONE = 0, MRET = 0, MASK_WE = 0;
  logic [3:0]  IRQ = 0, MASK_WD = 0;
  logic [31:0] CSR_MTVEC = 0, CSR_MEPC = 0;
  logic        INT_TAKEN, PC_REDIRECT, RESTORE_ME, MPIE;
  logic [31:0] PC_TARGET;
  logic [7:0]  CAUSE;
  logic [3:0]  PENDING, MASK;
  int n_chk = 0, n_fail = 0;
  logic [43:0] q[$];
  logic [43:0] e;

  otter_intr_ctrl #(.NUM_SRC(4), .SYNC_STAGES(2)) dut (
    .CLK(CLK), .RESET(RESET), .IRQ(IRQ), .CSR_ME(CSR_ME), .CSR_MTVEC(CSR_MTVEC),
    .CSR_MEPC(CSR_MEPC), .INSTR_DONE(INSTR_DONE), .MRET(MRET), .MASK_WE(MASK_WE),
    .MASK_WD(MASK_WD), .INT_TAKEN(INT_TAKEN), .PC_REDIRECT(PC_REDIRECT),
    .PC_TARGET(PC_TARGET), .RESTORE_ME(RESTORE_ME), .MPIE(MPIE), .CAUSE(CAUSE),
    .PENDING(PENDING), .MASK(MASK)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic expect_ev(input logic tk, input logic rs, input logic [31:0] tg, input logic [7:0] c, input logic mp);
    q.push_back({tk, rs, 1'b1, tg, c, mp});
  endtask

  task automatic instr(input logic m);
    INSTR_DONE = 1;
    MRET = m;
    tick();
    INSTR_DONE = 0;
    MRET = 0;
  endtask

  task automatic trap(input logic [7:0] c);
    expect_ev(1, 0, CSR_MTVEC, c, 1);
    instr(0);
  endtask

  task automatic mret(input logic [7:0] c);
    expect_ev(0, 1, CSR_MEPC, c, 1);
    instr(1);
  endtask

  // Any redirect/pulse must match the oldest expected event; unexpected ones fail.
  always @(negedge CLK) begin
    if (!RESET && (INT_TAKEN || PC_REDIRECT || RESTORE_ME)) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_event: got %0h expected none",
                 {INT_TAKEN, RESTORE_ME, PC_REDIRECT, PC_TARGET, CAUSE, MPIE});
      end else begin
        e = q.pop_front();
        chk("event", {20'b0, INT_TAKEN, RESTORE_ME, PC_REDIRECT, PC_TARGET, CAUSE, MPIE}, {20'b0, e});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    tick(2);
    RESET = 0;
    chk("rst_pending", PENDING, 0);
    chk("rst_mask", MASK, 4'hF);
    chk("rst_pulses", {INT_TAKEN, PC_REDIRECT, RESTORE_ME}, 0);
    chk("rst_target", PC_TARGET, 0);
    chk("rst_cause_mpie", {CAUSE, MPIE}, 0);
    CSR_ME = 1; CSR_MTVEC = 32'h100; CSR_MEPC = 32'h40;
    IRQ[2] = 1;
    tick(4);
    chk("basic_pending", PENDING, 4'b0100);
    trap(2);
    chk("basic_cleared", PENDING, 0);
    mret(2);
    IRQ = 4'b1010;
    tick(4);
    chk("prio_pending", PENDING, 4'b1010);
    trap(1);
    chk("prio_left", PENDING, 4'b1000);
    repeat (3) instr(0);
    CSR_MEPC = 32'h2C;
    mret(1);
    trap(3);
    chk("prio_empty", PENDING, 0);
    mret(3);
    IRQ = 0;
    tick(3);
    MASK_WD = 4'b1110; MASK_WE = 1;
    tick();
    MASK_WE = 0;
    chk("mask_write", MASK, 4'b1110);
    IRQ[0] = 1;
    tick(4);
    chk("mask_pend", PENDING, 4'b0001);
    instr(0);
    chk("mask_held", PENDING, 4'b0001);
    MASK_WD = 4'hF; MASK_WE = 1;
    tick();
    MASK_WE = 0;
    chk("mask_open", MASK, 4'hF);
    trap(0);
    mret(0);
    IRQ = 0;
    CSR_ME = 0;
    IRQ[3] = 1;
    tick(4);
    repeat (10) instr(0);
    chk("me_off_pend", PENDING, 4'b1000);
    CSR_ME = 1;
    trap(3);
    mret(3);
    IRQ = 0;
    tick(3);
    IRQ[1] = 1;
    tick(4);
    chk("level_pend", PENDING, 4'b0010);
    trap(1);
    mret(1);
    tick(45);
    chk("level_once", PENDING, 0);
    IRQ[1] = 0;
    tick(3);
    IRQ[1] = 1;
    tick(4);
    chk("level_rearm", PENDING, 4'b0010);
    trap(1);
    mret(1);
    IRQ = 0;
    tick(3);
    mret(1);
    IRQ[0] = 1;
    tick(4);
    IRQ[0] = 0;
    tick(3);
    IRQ[0] = 1;
    tick(2);
    trap(0);
    chk("set_wins", PENDING, 4'b0001);
    mret(0);
    trap(0);
    chk("set_wins_clear", PENDING, 0);
    mret(0);
    IRQ = 0;
    tick(3);
    IRQ[1] = 1;
    tick(4);
    trap(1);
    IRQ[2] = 1;
    tick(4);
    chk("hdl_pend", PENDING, 4'b0100);
    MASK_WD = 0; MASK_WE = 1;
    tick();
    MASK_WE = 0;
    RESET = 1;
    tick();
    chk("rst2_pending", PENDING, 0);
    chk("rst2_cause", CAUSE, 0);
    chk("rst2_mask", MASK, 4'hF);
    chk("rst2_pulses", {INT_TAKEN, PC_REDIRECT, RESTORE_ME, MPIE}, 0);
    chk("rst2_target", PC_TARGET, 0);
    RESET = 0;
    tick(4);
    chk("rst2_rearm", PENDING, 4'b0110);
    trap(1);
    chk("rst2_left", PENDING, 4'b0100);
    mret(1);
    tick(3);
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
